// File: rtl/axis_quad_stream_scheduler_if.sv
// axis_quad_stream_scheduler_if: four AXI-Stream sources in, one tagged AXI-Stream out
interface axis_quad_stream_scheduler_if #(parameter int DATA_WIDTH = 128, parameter int NUM_CH = 4);
  logic [NUM_CH*DATA_WIDTH-1:0] s_axis_tdata;
  logic [NUM_CH-1:0]            s_axis_tvalid;
  logic [NUM_CH-1:0]            s_axis_tlast;
  logic [NUM_CH-1:0]            s_axis_tready;
  logic [DATA_WIDTH-1:0]        m_axis_tdata;
  logic [DATA_WIDTH/8-1:0]      m_axis_tkeep;
  logic [1:0]                   m_axis_tid;
  logic                         m_axis_tlast;
  logic                         m_axis_tvalid;
  logic                         m_axis_tready;
  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tid, m_axis_tlast, m_axis_tvalid
  );
  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tid, m_axis_tlast, m_axis_tvalid
  );
endinterface

// File: rtl/axis_quad_stream_scheduler.sv
// axis_quad_stream_scheduler: packet-granular round-robin merge of 4 streams into one registered output
module axis_quad_stream_scheduler #(
  parameter int DATA_WIDTH = 128,
  parameter int NUM_CH = 4
) (
  input  logic CLK,
  input  logic reset,
  axis_quad_stream_scheduler_if.slave bus,
  output logic [1:0] grant_id,
  output logic busy
);
  typedef enum logic {IDLE, STREAM} state_t;
  state_t state, state_next;
  logic [1:0] pick;
  logic found, accept, sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  always_comb begin
    pick = grant_id;
    found = 1'b0;
    for (int j = 1; j <= 4; j++)
      if (!found && bus.s_axis_tvalid[2'(grant_id + 2'(j))]) begin
        pick = 2'(grant_id + 2'(j));
        found = 1'b1;
      end
    bus.s_axis_tready = (state == STREAM && (!bus.m_axis_tvalid || bus.m_axis_tready))
                        ? NUM_CH'(1) << grant_id : '0;
    accept = |(bus.s_axis_tready & bus.s_axis_tvalid);
    sel_data = bus.s_axis_tdata[grant_id*DATA_WIDTH +: DATA_WIDTH];
    sel_last = bus.s_axis_tlast[grant_id];
    state_next = state == IDLE ? (found ? STREAM : IDLE) : (accept && sel_last ? IDLE : STREAM);
  end
  assign busy = state == STREAM;
  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= IDLE;
      grant_id <= 2'd3;
      bus.m_axis_tdata <= '0;
      bus.m_axis_tkeep <= '0;
      bus.m_axis_tid <= '0;
      bus.m_axis_tlast <= 1'b0;
      bus.m_axis_tvalid <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && found) grant_id <= pick;
      if (accept) begin
        bus.m_axis_tdata <= sel_data;
        bus.m_axis_tkeep <= '1;
        bus.m_axis_tid <= grant_id;
        bus.m_axis_tlast <= sel_last;
        bus.m_axis_tvalid <= 1'b1;
      end else if (bus.m_axis_tready) begin
        // drained with nothing new behind it: present an all-zero idle beat
        bus.m_axis_tdata <= '0;
        bus.m_axis_tkeep <= '0;
        bus.m_axis_tvalid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_axis_quad_stream_scheduler.sv
// tb_axis_quad_stream_scheduler: directed checks of arbitration order, latency, backpressure and reset
module tb_axis_quad_stream_scheduler;
  logic CLK = 1'b0;
  logic reset;
  logic [1:0] grant_id;
  logic busy;
  int n_chk = 0;
  int n_fail = 0;
  axis_quad_stream_scheduler_if bus();
  axis_quad_stream_scheduler dut (.CLK(CLK), .reset(reset), .bus(bus), .grant_id(grant_id), .busy(busy));
  always #5 CLK = ~CLK;

  function automatic logic [127:0] mk(input int c, input int b);
    return {16{8'(c*16 + b + 1)}};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [127:0] d, input int id, input logic l);
    chk({tag, ".tvalid"}, 128'(bus.m_axis_tvalid), 128'(v));
    chk({tag, ".tdata"}, bus.m_axis_tdata, v ? d : 128'd0);
    chk({tag, ".tkeep"}, 128'(bus.m_axis_tkeep), v ? 128'hffff : 128'd0);
    if (v) begin
      chk({tag, ".tid"}, 128'(bus.m_axis_tid), 128'(id));
      chk({tag, ".tlast"}, 128'(bus.m_axis_tlast), 128'(l));
    end
  endtask

  task automatic set_ch(input int c, input logic v, input int b, input logic l);
    bus.s_axis_tvalid[c] = v;
    bus.s_axis_tlast[c] = l;
    bus.s_axis_tdata[c*128 +: 128] = mk(c, b);
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_all;
    for (int c = 0; c < 4; c++) set_ch(c, 1'b0, 0, 1'b0);
  endtask

  initial begin
    int order [5] = '{0, 1, 2, 3, 0};
    reset = 1'b1;
    bus.m_axis_tready = 1'b1;
    clear_all();
    tick();
    tick();
    reset = 1'b0;
    // reset state
    chk_out("rst", 1'b0, '0, 0, 1'b0);
    chk("rst.tid", 128'(bus.m_axis_tid), 128'd0);
    chk("rst.tlast", 128'(bus.m_axis_tlast), 128'd0);
    chk("rst.grant", 128'(grant_id), 128'd3);
    chk("rst.busy", 128'(busy), 128'd0);
    chk("rst.tready", 128'(bus.s_axis_tready), 128'd0);
    // ch0 alone, 4-beat packet, one cycle accept-to-output latency
    set_ch(0, 1'b1, 0, 1'b0);
    #1 chk("t1.idle_tready", 128'(bus.s_axis_tready), 128'd0);
    tick();
    chk("t1.grant", 128'(grant_id), 128'd0);
    chk("t1.busy", 128'(busy), 128'd1);
    chk("t1.pre_valid", 128'(bus.m_axis_tvalid), 128'd0);
    for (int b = 0; b < 4; b++) begin
      set_ch(0, 1'b1, b, b == 3);
      #1 chk("t1.tready", 128'(bus.s_axis_tready), 128'b0001);
      tick();
      chk_out("t1.out", 1'b1, mk(0, b), 0, b == 3);
    end
    clear_all();
    chk("t1.busy_end", 128'(busy), 128'd0);
    chk("t1.grant_kept", 128'(grant_id), 128'd0);
    tick();
    chk_out("t1.drain", 1'b0, '0, 0, 1'b0);
    // all four contending, 2-beat packets, round robin from a fresh reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) set_ch(c, 1'b1, 0, 1'b0);
    foreach (order[k]) begin
      tick();
      chk("t2.grant", 128'(grant_id), 128'(order[k]));
      chk("t2.busy", 128'(busy), 128'd1);
      chk("t2.bubble", 128'(bus.m_axis_tvalid), 128'd0);
      for (int b = 0; b < 2; b++) begin
        set_ch(order[k], 1'b1, b, b == 1);
        #1 chk("t2.tready", 128'(bus.s_axis_tready), 128'(4'b0001 << order[k]));
        tick();
        chk_out("t2.out", 1'b1, mk(order[k], b), order[k], b == 1);
      end
      chk("t2.idle", 128'(busy), 128'd0);
      set_ch(order[k], 1'b1, 0, 1'b0);
    end
    clear_all();
    tick();
    chk_out("t2.drain", 1'b0, '0, 0, 1'b0);
    // ch1 packet stalled downstream for 3 cycles
    set_ch(1, 1'b1, 0, 1'b0);
    tick();
    chk("t3.grant", 128'(grant_id), 128'd1);
    tick();
    chk_out("t3.b0", 1'b1, mk(1, 0), 1, 1'b0);
    bus.m_axis_tready = 1'b0;
    set_ch(1, 1'b1, 1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("t3.stall_tready", 128'(bus.s_axis_tready), 128'd0);
      tick();
      chk_out("t3.hold", 1'b1, mk(1, 0), 1, 1'b0);
    end
    bus.m_axis_tready = 1'b1;
    #1 chk("t3.resume_tready", 128'(bus.s_axis_tready), 128'b0010);
    tick();
    chk_out("t3.b1", 1'b1, mk(1, 1), 1, 1'b0);
    set_ch(1, 1'b1, 2, 1'b1);
    tick();
    chk_out("t3.b2", 1'b1, mk(1, 2), 1, 1'b1);
    clear_all();
    tick();
    chk_out("t3.drain", 1'b0, '0, 0, 1'b0);
    // after ch2 served, ch1 and ch2 both request: search 3,0,1 -> ch1
    set_ch(2, 1'b1, 0, 1'b1);
    tick();
    chk("t4.grant2", 128'(grant_id), 128'd2);
    tick();
    chk_out("t4.ch2", 1'b1, mk(2, 0), 2, 1'b1);
    set_ch(1, 1'b1, 0, 1'b1);
    tick();
    chk("t4.grant1", 128'(grant_id), 128'd1);
    tick();
    chk_out("t4.ch1", 1'b1, mk(1, 0), 1, 1'b1);
    clear_all();
    tick();
    // reset in the middle of a ch3 packet
    set_ch(3, 1'b1, 0, 1'b0);
    tick();
    chk("t5.grant", 128'(grant_id), 128'd3);
    tick();
    set_ch(3, 1'b1, 1, 1'b0);
    tick();
    chk_out("t5.b1", 1'b1, mk(3, 1), 3, 1'b0);
    set_ch(3, 1'b1, 2, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_out("t5.rst", 1'b0, '0, 0, 1'b0);
    chk("t5.rst_tid", 128'(bus.m_axis_tid), 128'd0);
    chk("t5.rst_grant", 128'(grant_id), 128'd3);
    chk("t5.rst_busy", 128'(busy), 128'd0);
    chk("t5.rst_tready", 128'(bus.s_axis_tready), 128'd0);
    set_ch(0, 1'b1, 0, 1'b1);
    tick();
    chk("t5.ch0_wins", 128'(grant_id), 128'd0);
    #1 chk("t5.tready", 128'(bus.s_axis_tready), 128'b0001);
    tick();
    chk_out("t5.ch0", 1'b1, mk(0, 0), 0, 1'b1);
    clear_all();
    tick();
    // granted ch0 goes quiet mid-packet while ch1 waits
    set_ch(0, 1'b1, 0, 1'b0);
    tick();
    chk("t6.grant", 128'(grant_id), 128'd0);
    set_ch(1, 1'b1, 0, 1'b1);
    tick();
    chk_out("t6.b0", 1'b1, mk(0, 0), 0, 1'b0);
    set_ch(0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      #1 chk("t6.gap_tready", 128'(bus.s_axis_tready), 128'b0001);
      tick();
      chk("t6.gap_grant", 128'(grant_id), 128'd0);
      chk("t6.gap_busy", 128'(busy), 128'd1);
      chk("t6.gap_valid", 128'(bus.m_axis_tvalid), 128'd0);
    end
    set_ch(0, 1'b1, 1, 1'b1);
    tick();
    chk_out("t6.b1", 1'b1, mk(0, 1), 0, 1'b1);
    set_ch(0, 1'b0, 0, 1'b0);
    tick();
    chk("t6.grant1", 128'(grant_id), 128'd1);
    tick();
    chk_out("t6.ch1", 1'b1, mk(1, 0), 1, 1'b1);
    clear_all();
    tick();
    chk_out("t6.drain", 1'b0, '0, 0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
